// File: rtl/elevator_request_scheduler.sv
// ============================================================================
// Module   : elevator_request_scheduler
// Brief    : SCAN-style four-floor elevator call scheduler. Optional auto-home
//            feature is enabled by defining the macro AUTO_HOME_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module elevator_request_scheduler #(
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] call_req,
    input  logic [1:0] current_floor,
    input  logic       door_open,
    output logic [1:0] floor_request,
    output logic [1:0] dir,
    output logic [3:0] pending,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_UP   = 2'b01,
        S_DOWN = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] pending_q, pending_d;
    logic [1:0] floor_request_q, floor_request_d;

    logic       any_above, any_below, any_at;
    logic [1:0] lowest_at_above, highest_at_below;
    logic       home_set;

    // Classify outstanding calls relative to the car and pick SCAN candidates.
    always_comb begin
        any_above        = 1'b0;
        any_below        = 1'b0;
        any_at           = 1'b0;
        lowest_at_above  = current_floor;
        highest_at_below = current_floor;
        for (int i = 3; i >= 0; i--) begin
            if (pending_q[i] && (2'(i) >= current_floor)) begin
                lowest_at_above = 2'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (pending_q[i]) begin
                if (2'(i) > current_floor) begin
                    any_above = 1'b1;
                end
                if (2'(i) < current_floor) begin
                    any_below = 1'b1;
                end
                if (2'(i) == current_floor) begin
                    any_at = 1'b1;
                end
                if (2'(i) <= current_floor) begin
                    highest_at_below = 2'(i);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!door_open) begin
                    if (any_above) begin
                        state_d = S_UP;
                    end else if (any_below) begin
                        state_d = S_DOWN;
                    end
                end
            end
            S_UP: begin
                if (!door_open && !(any_above || any_at)) begin
                    state_d = any_below ? S_DOWN : S_IDLE;
                end
            end
            S_DOWN: begin
                if (!door_open && !(any_below || any_at)) begin
                    state_d = any_above ? S_UP : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The target follows the direction being entered; with nothing to serve
    // in that direction the car is told to hold where it is.
    always_comb begin
        floor_request_d = current_floor;
        if (state_d == S_UP && (any_above || any_at)) begin
            floor_request_d = lowest_at_above;
        end else if (state_d == S_DOWN && (any_below || any_at)) begin
            floor_request_d = highest_at_below;
        end
    end

`ifdef AUTO_HOME_EN
    localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);

    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0] idle_cnt_inc;
    logic             idle_counting;

    assign idle_cnt_inc  = idle_cnt_q + 1'b1;
    assign idle_counting = (state_q == S_IDLE) && (state_d == S_IDLE) &&
                           (pending_q == 4'b0000) && (call_req == 4'b0000) &&
                           (current_floor != 2'b00);

    always_comb begin
        idle_cnt_d = '0;
        home_set   = 1'b0;
        if (idle_counting) begin
            if (idle_cnt_inc == CNT_W'(IDLE_TIMEOUT)) begin
                home_set = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign home_set = 1'b0;
`endif

    // Serving a floor beats a call for that same floor in the same cycle.
    always_comb begin
        pending_d = pending_q | call_req | {3'b000, home_set};
        if (door_open) begin
            pending_d[current_floor] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            pending_q       <= 4'b0000;
            floor_request_q <= 2'b00;
        end else begin
            state_q         <= state_d;
            pending_q       <= pending_d;
            floor_request_q <= floor_request_d;
        end
    end

    assign floor_request = floor_request_q;
    assign dir           = state_q;
    assign pending       = pending_q;
    assign busy          = (pending_q != 4'b0000) || (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_elevator_request_scheduler.sv
// ============================================================================
// Module   : tb_elevator_request_scheduler
// Brief    : Directed self-checking bench for elevator_request_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_elevator_request_scheduler;

    logic       clk;
    logic       reset;
    logic [3:0] call_req;
    logic [1:0] current_floor;
    logic       door_open;
    logic [1:0] floor_request;
    logic [1:0] dir;
    logic [3:0] pending;
    logic       busy;

    int vectors;
    int miscompares;

    elevator_request_scheduler #(.IDLE_TIMEOUT(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .call_req      (call_req),
        .current_floor (current_floor),
        .door_open     (door_open),
        .floor_request (floor_request),
        .dir           (dir),
        .pending       (pending),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] floor);
        reset         = 1'b1;
        call_req      = 4'b0000;
        door_open     = 1'b0;
        current_floor = floor;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        call_req      = 4'b1111;
        door_open     = 1'b0;
        current_floor = 2'd2;
        tick();
        tick();
        vectors++;
        if ({pending, dir, floor_request, busy} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got pend=%b dir=%b req=%b busy=%b expected all zero",
                     pending, dir, floor_request, busy);
        end
        reset    = 1'b0;
        call_req = 4'b0000;
        tick();
        vectors++;
        if (pending !== 4'b0000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_calls_ignored: got pend=%b busy=%b expected 0000/0", pending, busy);
        end
        vectors++;
        if (floor_request !== 2'd2) begin
            miscompares++;
            $display("FAIL reset_idle_hold: got req=%0d expected 2", floor_request);
        end
    endtask

    task automatic test_basic_up();
        do_reset(2'd0);
        call_req = 4'b1000;
        tick();
        call_req = 4'b0000;
        vectors++;
        if (pending !== 4'b1000 || dir !== 2'b00 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_latch: got pend=%b dir=%b busy=%b expected 1000/00/1", pending, dir, busy);
        end
        tick();
        vectors++;
        if (dir !== 2'b01 || floor_request !== 2'd3) begin
            miscompares++;
            $display("FAIL basic_go_up: got dir=%b req=%0d expected 01/3", dir, floor_request);
        end
        current_floor = 2'd1; tick();
        current_floor = 2'd2; tick();
        current_floor = 2'd3; door_open = 1'b1; tick();
        vectors++;
        if (pending !== 4'b0000) begin
            miscompares++;
            $display("FAIL basic_served: got pend=%b expected 0000", pending);
        end
        tick();
        vectors++;
        if (dir !== 2'b01) begin
            miscompares++;
            $display("FAIL basic_door_hold: got dir=%b expected 01", dir);
        end
        door_open = 1'b0;
        tick();
        vectors++;
        if (dir !== 2'b00 || floor_request !== 2'd3 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_idle: got dir=%b req=%0d busy=%b expected 00/3/0", dir, floor_request, busy);
        end
    endtask

    task automatic test_scan_insert();
        do_reset(2'd1);
        call_req = 4'b1000;
        tick();
        call_req = 4'b0000;
        tick();
        call_req = 4'b0100;
        tick();
        call_req = 4'b0000;
        vectors++;
        if (pending !== 4'b1100 || floor_request !== 2'd3) begin
            miscompares++;
            $display("FAIL scan_pre: got pend=%b req=%0d expected 1100/3", pending, floor_request);
        end
        tick();
        vectors++;
        if (floor_request !== 2'd2 || dir !== 2'b01) begin
            miscompares++;
            $display("FAIL scan_retarget: got req=%0d dir=%b expected 2/01", floor_request, dir);
        end
        current_floor = 2'd2; door_open = 1'b1; tick();
        tick();
        door_open = 1'b0;
        vectors++;
        if (pending !== 4'b1000 || floor_request !== 2'd3) begin
            miscompares++;
            $display("FAIL scan_next: got pend=%b req=%0d expected 1000/3", pending, floor_request);
        end
    endtask

    task automatic test_reversal();
        do_reset(2'd2);
        call_req = 4'b1001;
        tick();
        call_req = 4'b0000;
        tick();
        vectors++;
        if (dir !== 2'b01 || floor_request !== 2'd3) begin
            miscompares++;
            $display("FAIL rev_up_first: got dir=%b req=%0d expected 01/3", dir, floor_request);
        end
        current_floor = 2'd3; door_open = 1'b1; tick();
        tick();
        vectors++;
        if (pending !== 4'b0001 || dir !== 2'b01) begin
            miscompares++;
            $display("FAIL rev_door_hold: got pend=%b dir=%b expected 0001/01", pending, dir);
        end
        door_open = 1'b0;
        tick();
        vectors++;
        if (dir !== 2'b10 || floor_request !== 2'd0) begin
            miscompares++;
            $display("FAIL rev_down: got dir=%b req=%0d expected 10/0", dir, floor_request);
        end
    endtask

    task automatic test_tie();
        do_reset(2'd1);
        call_req = 4'b1001;
        tick();
        call_req = 4'b0000;
        tick();
        vectors++;
        if (dir !== 2'b01 || floor_request !== 2'd3) begin
            miscompares++;
            $display("FAIL tie_up_wins: got dir=%b req=%0d expected 01/3", dir, floor_request);
        end
    endtask

    task automatic test_clear_and_midreset();
        do_reset(2'd2);
        call_req = 4'b0100;
        tick();
        call_req = 4'b0000;
        tick();
        vectors++;
        if (dir !== 2'b00 || floor_request !== 2'd2 || pending !== 4'b0100) begin
            miscompares++;
            $display("FAIL at_floor_idle: got dir=%b req=%0d pend=%b expected 00/2/0100",
                     dir, floor_request, pending);
        end
        door_open = 1'b1;
        call_req  = 4'b0100;
        tick();
        door_open = 1'b0;
        call_req  = 4'b0000;
        vectors++;
        if (pending !== 4'b0000) begin
            miscompares++;
            $display("FAIL clear_wins: got pend=%b expected 0000", pending);
        end
        current_floor = 2'd0;
        call_req = 4'b1000;
        tick();
        call_req = 4'b0000;
        tick();
        reset = 1'b1;
        #1;
        vectors++;
        if ({pending, dir, floor_request, busy} !== 9'b0) begin
            miscompares++;
            $display("FAIL midtravel_reset: got pend=%b dir=%b req=%b busy=%b expected all zero",
                     pending, dir, floor_request, busy);
        end
        do_reset(2'd0);
    endtask

    task automatic test_floor0_boundary();
        do_reset(2'd0);
        call_req = 4'b0001;
        tick();
        call_req = 4'b0000;
        tick();
        vectors++;
        if (dir !== 2'b00 || floor_request !== 2'd0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL floor0_stay: got dir=%b req=%0d busy=%b expected 00/0/1", dir, floor_request, busy);
        end
        door_open = 1'b1;
        tick();
        door_open = 1'b0;
        vectors++;
        if (pending !== 4'b0000) begin
            miscompares++;
            $display("FAIL floor0_clear: got pend=%b expected 0000", pending);
        end
    endtask

    task automatic test_auto_home();
        int waited;
        do_reset(2'd2);
        waited = 0;
`ifdef AUTO_HOME_EN
        while (pending[0] !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        vectors++;
        if (pending !== 4'b0001 || waited != 16) begin
            miscompares++;
            $display("FAIL home_request: got pend=%b after %0d cycles expected 0001 after 16",
                     pending, waited);
        end
        tick();
        vectors++;
        if (dir !== 2'b10 || floor_request !== 2'd0) begin
            miscompares++;
            $display("FAIL home_go_down: got dir=%b req=%0d expected 10/0", dir, floor_request);
        end
`else
        while (waited < 40) begin
            tick();
            waited++;
        end
        vectors++;
        if (dir !== 2'b00 || pending !== 4'b0000 || floor_request !== 2'd2) begin
            miscompares++;
            $display("FAIL no_home: got dir=%b pend=%b req=%0d expected 00/0000/2",
                     dir, pending, floor_request);
        end
`endif
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        call_req      = 4'b0000;
        current_floor = 2'd0;
        door_open     = 1'b0;
        test_reset();
        test_basic_up();
        test_scan_insert();
        test_reversal();
        test_tie();
        test_clear_and_midreset();
        test_floor0_boundary();
        test_auto_home();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/elevator_request_scheduler.md
ELEVATOR_REQUEST_SCHEDULER -- requirements
Module: elevator_request_scheduler

Interface
REQ-001 Parameter: IDLE_TIMEOUT, 16, idle cycles before auto-home request (used only with AUTO_HOME_EN).
REQ-002 Clocking and reset: reset is asynchronous and active-high; the clock is clk.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 call_req  input  4  per-floor call buttons, bit F = floor F, level or pulse, sampled each cycle.
REQ-006 current_floor  input  2  floor the car is at (from position sensor).
REQ-007 door_open  input  1  car door open indication from the motion controller.
REQ-008 floor_request  output  2  target floor driven to the motion controller, registered.
REQ-009 dir  output  2  scan direction: 00 idle, 01 up, 10 down, registered.
REQ-010 pending  output  4  latched outstanding calls, bit F = floor F.
REQ-011 busy  output  1  high when any pending bit set or dir != 00.

Function
REQ-012 Any call_req[F]=1 shall set pending[F] on the next edge; pending bits are sticky until served.
REQ-013 pending[F] shall clear on the edge where door_open=1 and current_floor=F; if call_req[F] is also 1 that cycle, clear wins.
REQ-014 FSM states: S_IDLE, S_UP, S_DOWN; state encodes dir (00/01/10).
REQ-015 S_IDLE: if pending has bit above current_floor -> S_UP; else if bit below -> S_DOWN; else stay; bit at current_floor only -> stay, floor_request = current_floor.
REQ-016 S_UP: floor_request = lowest pending floor >= current_floor; if none at or above and some below -> S_DOWN; if none -> S_IDLE.
REQ-017 S_DOWN: floor_request = highest pending floor <= current_floor; if none at or below and some above -> S_UP; if none -> S_IDLE.
REQ-018 Ties: from S_IDLE with pending both above and below, up shall win.
REQ-019 A new call ahead in the current direction shall be served before the current target (SCAN); calls behind wait for reversal.
REQ-020 floor_request and dir shall update one cycle after the pending/current_floor change that causes them (1-cycle latency).
REQ-021 With no pending, floor_request shall hold current_floor so the motion controller sees request == floor.
REQ-022 Floors are 0..3; floor comparisons unsigned 2-bit; no wrap-around (floor 3 never moves up, floor 0 never moves down).
REQ-023 Direction shall not change while door_open=1; reversal evaluated on the first cycle door_open=0.

Reset
REQ-024 Asserting reset at any time, including mid-travel, shall immediately force pending=0000, dir=00, state S_IDLE, floor_request=00, busy=0, idle counter=0.
REQ-025 Calls present during reset shall be ignored; sampling resumes on first edge after deassertion.

Configuration
REQ-026 Macro AUTO_HOME_EN: when defined, a counter shall count cycles in S_IDLE with pending=0000 and current_floor!=0, and on reaching IDLE_TIMEOUT set pending[0] and clear the counter; any call or state change clears the counter.
REQ-027 Without AUTO_HOME_EN: no counter is built, the car shall remain at its last floor indefinitely when idle.

Verification
REQ-028 Reset, current_floor=0, pulse call_req=1000 -> pending=1000 next edge, dir=01 and floor_request=11 one cycle later; door_open at floor 3 -> pending=0000, dir=00.
REQ-029 Car at floor 1 moving up to 3, inject call_req=0100 -> floor_request changes 11->10; floor 2 served before 3.
REQ-030 Car at floor 2 in S_UP, pending=1001 -> serves 3, then reverses to S_DOWN, floor_request=00.
REQ-031 Idle at floor 1, pending=1001 simultaneously -> dir=01 (up wins), floor_request=11.
REQ-032 door_open=1 at floor 2 with call_req=0100 same cycle -> pending[2]=0; assert reset mid-travel -> all outputs zero same cycle.
REQ-033 AUTO_HOME_EN defined, idle at floor 2, no calls for 16 cycles -> pending=0001, dir=10, floor_request=00; undefined -> dir stays 00.
